// File: rtl/isp_pkg.sv
// isp_pkg: shared FSM states and constants for the ISP request responder.
package isp_pkg;
    localparam int PIC_NUM = 16;
    localparam int DATA_W = 8;
    localparam logic MODE_FOCUS = 1'b0;
    localparam logic MODE_EXPOSE = 1'b1;
    localparam logic [1:0] RATIO_1X = 2'd2;
    typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_ISSUE, S_WAIT, S_RESP} state_t;
endpackage

// File: rtl/isp_result_cache.sv
// isp_result_cache: per-picture focus/exposure result cache, one comb read port, one write port.
module isp_result_cache #(
    parameter int PIC_NUM = isp_pkg::PIC_NUM,
    parameter int DATA_W = isp_pkg::DATA_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [$clog2(PIC_NUM)-1:0] rd_idx,
    output logic [DATA_W-1:0]          rd_focus_val,
    output logic                       rd_focus_vld,
    output logic [DATA_W-1:0]          rd_exp_val,
    output logic                       rd_exp_vld,
    input  logic                       wr_en,
    input  logic                       wr_mode,
    input  logic [$clog2(PIC_NUM)-1:0] wr_idx,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic                       inv_focus
);
    import isp_pkg::*;
    logic [PIC_NUM-1:0] focus_vld, exp_vld;
    logic [DATA_W-1:0] focus_val [PIC_NUM];
    logic [DATA_W-1:0] exp_val [PIC_NUM];

    assign rd_focus_val = focus_val[rd_idx];
    assign rd_focus_vld = focus_vld[rd_idx];
    assign rd_exp_val = exp_val[rd_idx];
    assign rd_exp_vld = exp_vld[rd_idx];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            focus_vld <= '0;
            exp_vld <= '0;
        end else begin
            if (wr_en && wr_mode == MODE_FOCUS) focus_vld[wr_idx] <= 1'b1;
            if (wr_en && wr_mode == MODE_EXPOSE) exp_vld[wr_idx] <= 1'b1;
            if (inv_focus) focus_vld[wr_idx] <= 1'b0;
        end
    end

    // Data words carry no reset; the valid bits alone qualify them.
    always_ff @(posedge clk) begin
        if (wr_en && wr_mode == MODE_FOCUS) focus_val[wr_idx] <= wr_data;
        if (wr_en && wr_mode == MODE_EXPOSE) exp_val[wr_idx] <= wr_data;
    end
endmodule

// File: rtl/isp_req_responder.sv
// isp_req_responder: cached request responder in front of the ISP compute engine.
// Define ISP_RESP_TIMEOUT_EN to add a WAIT timeout (8'hFF result, sticky timeout_err).
module isp_req_responder #(
    parameter int PIC_NUM = isp_pkg::PIC_NUM,
    parameter int DATA_W = isp_pkg::DATA_W,
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [3:0]        in_pic_no,
    input  logic              in_mode,
    input  logic [1:0]        in_ratio_mode,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              eng_req,
    output logic [3:0]        eng_pic_no,
    output logic              eng_mode,
    output logic [1:0]        eng_ratio,
    input  logic              eng_ack,
    input  logic              eng_done,
    input  logic [DATA_W-1:0] eng_data,
`ifdef ISP_RESP_TIMEOUT_EN
    output logic              timeout_err,
`endif
    output logic              err_overlap
);
    import isp_pkg::*;
    localparam int IW = $clog2(PIC_NUM);
    state_t state;
    logic [3:0] pic;
    logic mode;
    logic [1:0] ratio;
    logic [DATA_W-1:0] focus_val, exp_val, hit_val;
    logic focus_vld, exp_vld, hit, wr_en;
`ifdef ISP_RESP_TIMEOUT_EN
    logic [10:0] wait_cnt;
`endif

    assign hit = mode == MODE_FOCUS ? focus_vld : ratio == RATIO_1X && exp_vld;
    assign hit_val = mode == MODE_FOCUS ? focus_val : exp_val;
    assign wr_en = state == S_WAIT && eng_done;

    isp_result_cache #(.PIC_NUM(PIC_NUM), .DATA_W(DATA_W)) u_cache (
        .clk(clk),
        .rst(rst),
        .rd_idx(pic[IW-1:0]),
        .rd_focus_val(focus_val),
        .rd_focus_vld(focus_vld),
        .rd_exp_val(exp_val),
        .rd_exp_vld(exp_vld),
        .wr_en(wr_en),
        .wr_mode(mode),
        .wr_idx(pic[IW-1:0]),
        .wr_data(eng_data),
        .inv_focus(wr_en && mode == MODE_EXPOSE && ratio != RATIO_1X)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            pic <= '0;
            mode <= 1'b0;
            ratio <= '0;
            out_valid <= 1'b0;
            out_data <= '0;
            eng_req <= 1'b0;
            eng_pic_no <= '0;
            eng_mode <= 1'b0;
            eng_ratio <= '0;
            err_overlap <= 1'b0;
`ifdef ISP_RESP_TIMEOUT_EN
            wait_cnt <= '0;
            timeout_err <= 1'b0;
`endif
        end else begin
            if (in_valid && state != S_IDLE) err_overlap <= 1'b1;
            out_valid <= 1'b0;
            out_data <= '0;
            case (state)
                S_IDLE: if (in_valid) begin
                    pic <= in_pic_no;
                    mode <= in_mode;
                    ratio <= in_ratio_mode;
                    state <= S_LOOKUP;
                end
                S_LOOKUP: if (hit) begin
                    out_valid <= 1'b1;
                    out_data <= hit_val;
                    state <= S_RESP;
                end else begin
                    eng_req <= 1'b1;
                    eng_pic_no <= pic;
                    eng_mode <= mode;
                    eng_ratio <= ratio;
                    state <= S_ISSUE;
                end
                S_ISSUE: if (eng_ack) begin
                    eng_req <= 1'b0;
                    state <= S_WAIT;
`ifdef ISP_RESP_TIMEOUT_EN
                    wait_cnt <= '0;
`endif
                end
                S_WAIT: if (eng_done) begin
                    out_valid <= 1'b1;
                    out_data <= eng_data;
                    state <= S_RESP;
                end
`ifdef ISP_RESP_TIMEOUT_EN
                else if (wait_cnt == 11'(TIMEOUT_CYC - 1)) begin
                    out_valid <= 1'b1;
                    out_data <= '1;
                    timeout_err <= 1'b1;
                    state <= S_RESP;
                end else wait_cnt <= wait_cnt + 11'd1;
`endif
                S_RESP: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: doc/isp_req_responder.md
Name: isp_req_responder

Overview:
- Command-side responder of the ISP midterm datapath. It accepts the one-cycle request (picture number, mode, ratio) and returns exactly one out_valid/out_data pulse per request.
- It keeps a per-picture result cache so that repeated auto-focus requests, and 1x-exposure requests, are answered without touching the compute engine.
- Cache misses are forwarded to the DRAM-backed compute engine over a req/ack + done handshake.
- It sits between the top-level ISP pins and the engine.

Parameters:
- PIC_NUM, 16, number of pictures / cache entries (index width = clog2(PIC_NUM)).
- DATA_W, 8, result width.
- TIMEOUT_CYC, 1000, maximum WAIT cycles (used only with the optional feature).

Ports:
- clk  in  1  system clock; one clock domain; all flops rising-edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  one-cycle request strobe.
- in_pic_no  in  4  picture index.
- in_mode  in  1  0 = auto-focus, 1 = auto-exposure.
- in_ratio_mode  in  2  exposure ratio: 0 = x0.25, 1 = x0.5, 2 = x1, 3 = x2.
- out_valid  out  1  one-cycle response strobe.
- out_data  out  DATA_W  result; 0 whenever out_valid = 0.
- eng_req  out  1  engine request; held until accepted.
- eng_pic_no  out  4  registered request fields, stable while eng_req = 1.
- eng_mode  out  1  registered request field, stable while eng_req = 1.
- eng_ratio  out  2  registered request field, stable while eng_req = 1.
- eng_ack  in  1  engine accepts; transfer occurs when eng_req & eng_ack.
- eng_done  in  1  one-cycle result strobe from engine.
- eng_data  in  DATA_W  engine result, valid with eng_done.
- err_overlap  out  1  sticky error; set on in_valid while not IDLE.

Behaviour:
- Reset (async, rst = 1):
  - state = IDLE.
  - out_valid = 0, out_data = 0, eng_req = 0, eng_* fields = 0, err_overlap = 0.
  - All cache valid bits = 0.
- FSM states: IDLE, LOOKUP, ISSUE, WAIT, RESP.
- IDLE:
  - On in_valid, latch pic/mode/ratio and go to LOOKUP.
  - in_valid = 0 keeps the FSM in IDLE.
- LOOKUP (exactly 1 cycle):
  - Hit if mode 0 and focus_vld[pic] = 1; result = focus_val[pic].
  - Hit if mode 1, ratio = 2 and exp_vld[pic] = 1; result = exp_val[pic].
  - On a hit, go to RESP. Otherwise go to ISSUE.
- ISSUE: eng_req = 1 with registered fields. On eng_ack in the same cycle, eng_req drops next cycle and the FSM goes to WAIT.
- WAIT:
  - On eng_done, capture eng_data as the result and update the cache (same edge), then go to RESP.
  - Mode 0 update: focus_val[pic] = eng_data, focus_vld[pic] = 1.
  - Mode 1 update: exp_val[pic] = eng_data, exp_vld[pic] = 1. If ratio != 2, also clear focus_vld[pic] (the image was modified).
- RESP: out_valid = 1 and out_data = result for exactly 1 cycle, then IDLE.
- Latency:
  - Cache hit: out_valid in the 2nd cycle after the in_valid sampling edge.
  - Miss: 3 cycles plus ack wait plus engine time.
- Overlap: in_valid in any state other than IDLE is ignored (no latch, no second response) and sets err_overlap until reset.
- RESP and in_valid in the same cycle count as an overlap. in_valid in the cycle after RESP is legal.
- eng_done outside WAIT is ignored.
- eng_ack without eng_req is ignored.
- Reset mid-operation aborts: no response is issued and the cache is cleared.
- Cache updates only ever touch the entry of the latched picture; other entries are untouched.

Optional Feature:
- Macro: ISP_RESP_TIMEOUT_EN.
- Defined:
  - A WAIT-cycle counter (11 bits) is active.
  - If TIMEOUT_CYC cycles elapse without eng_done, go to RESP with out_data = 8'hFF.
  - The cache is not updated, and extra output timeout_err (1 bit, sticky) is set.
  - A late eng_done is ignored.
- Undefined: no counter, no timeout_err port; WAIT waits indefinitely.

Decomposition:
- Package isp_pkg:
  - State enum.
  - Constants MODE_FOCUS = 0, MODE_EXPOSE = 1, RATIO_1X = 2'd2, PIC_NUM, DATA_W.
- Sub-module isp_result_cache:
  - PIC_NUM x (focus_val, focus_vld, exp_val, exp_vld).
  - 1 read port (combinational by index) and 1 write port with separate invalidate-focus control.
  - Async reset of valid bits only.

Test Plan:
- Reset pulse mid-run -> out_valid = 0, out_data = 0, eng_req = 0, err_overlap = 0 immediately (async).
- pic 3, mode 0, engine acks after 2 cycles and returns 8'd37 -> one out_valid pulse with 37. Repeat the same request -> 37 in 2 cycles with no eng_req.
- pic 3, mode 1, ratio 0 (miss, engine returns 8'd60) -> 60. Then pic 3 mode 0 -> eng_req asserted (focus invalidated). Then pic 3 mode 1 ratio 2 -> 60 from cache, no eng_req.
- in_valid pulsed during WAIT -> err_overlap = 1, still exactly one response for the first request.
- Engine holds eng_ack low 5 cycles -> eng_req and eng_* fields stable throughout; no response before eng_done.
- With ISP_RESP_TIMEOUT_EN, engine never answers -> out_data = 8'hFF after 1000 WAIT cycles and timeout_err = 1; a later eng_done is ignored.
